// File: rtl/bios_loader.sv
// bios_loader: copies BOOT_SIZE 32-bit instructions from a chunked BIOS bus into
// instruction memory, one word per cycle, then releases the processor.
//
// Ports:
//   clock         in   system clock, all state on rising edge
//   reset         in   asynchronous active-high reset
//   start         in   begin (or restart from DONE) a boot copy
//   instructions  in   BIOS chunk, word k at bits [32k+31:32k]
//   send          out  one-cycle request for the next chunk
//   mem_addr      out  instruction-memory write address
//   mem_data      out  instruction-memory write data
//   mem_we        out  instruction-memory write enable
//   busy          out  copy in progress (leaving IDLE until entering DONE)
//   done          out  copy complete (sticky)
//   cpu_hold      out  processor held in reset, NOT done
module bios_loader #(
   parameter int unsigned BOOT_SIZE   = 109,
   parameter int unsigned CHUNK_WORDS = 5,
   parameter int unsigned ADDR_W      = 10
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [32*CHUNK_WORDS-1:0] instructions,
   output logic                      send,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [31:0]               mem_data,
   output logic                      mem_we,
   output logic                      busy,
   output logic                      done,
   output logic                      cpu_hold
);

   localparam int unsigned CNT_W = $clog2(BOOT_SIZE + 1);
   localparam int unsigned K_W   = $clog2(CHUNK_WORDS + 1);
   localparam int unsigned BUS_W = 32 * CHUNK_WORDS;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StLatch,
      StWrite,
      StDone
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;     // words issued so far == next write address
   logic [K_W-1:0]     r_k;       // words issued from the current chunk
   logic [BUS_W-1:0]   r_chunk;   // remaining chunk words, next one in [31:0]
   logic               r_send;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [31:0]        r_mem_data;
   logic               r_mem_we;
   logic               r_busy;
   logic               r_done;
   logic               r_cpu_hold;

   logic               w_all_written;
   logic               w_chunk_empty;

   assign w_all_written = (r_cnt == CNT_W'(BOOT_SIZE));
   assign w_chunk_empty = (r_k == K_W'(CHUNK_WORDS));

   // Outputs are registered, so each state computes the outputs seen in the
   // following cycle: the LATCH edge already presents word 0 for the first
   // WRITE cycle, and each WRITE edge presents the next word or leaves.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_k        <= '0;
         r_chunk    <= '0;
         r_send     <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_mem_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cpu_hold <= 1'b1;
      end else begin
         case (r_state)
            StIdle, StDone: begin
               if (start) begin
                  r_state    <= StReq;
                  r_cnt      <= '0;
                  r_send     <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_cpu_hold <= 1'b1;
               end
            end
            StReq: begin
               r_state <= StWait;
               r_send  <= 1'b0;
            end
            // BIOS registers its bus on the edge that sampled send.
            StWait: begin
               r_state <= StLatch;
            end
            StLatch: begin
               r_state    <= StWrite;
               r_chunk    <= instructions >> 32;
               r_k        <= K_W'(1);   // word 0 issued on this edge
               r_mem_we   <= 1'b1;
               r_mem_data <= instructions[31:0];
               r_mem_addr <= ADDR_W'(r_cnt);
               r_cnt      <= r_cnt + CNT_W'(1);
            end
            StWrite: begin
               if (w_chunk_empty || w_all_written) begin
                  // Unissued words of a partial final chunk are dropped here.
                  r_mem_we <= 1'b0;
                  if (w_all_written) begin
                     r_state    <= StDone;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end else begin
                     r_state <= StReq;
                     r_send  <= 1'b1;
                  end
               end else begin
                  r_mem_we   <= 1'b1;
                  r_mem_data <= r_chunk[31:0];
                  r_chunk    <= r_chunk >> 32;
                  r_mem_addr <= ADDR_W'(r_cnt);
                  r_cnt      <= r_cnt + CNT_W'(1);
                  r_k        <= r_k + K_W'(1);
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign send     = r_send;
   assign mem_addr = r_mem_addr;
   assign mem_data = r_mem_data;
   assign mem_we   = r_mem_we;
   assign busy     = r_busy;
   assign done     = r_done;
   assign cpu_hold = r_cpu_hold;

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: randomized self-checking bench for bios_loader. A BIOS model
// serves chunks of a random boot image; the expected memory image is simply the
// first BOOT words of that image, written once each at ascending addresses.
module tb_bios_loader;

   localparam int unsigned BOOT = 109;
   localparam int unsigned CW   = 5;
   localparam int unsigned AW   = 10;
   localparam int unsigned NCH  = (BOOT + CW - 1) / CW;
   localparam int unsigned IMG  = NCH * CW;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [32*CW-1:0]  instructions = '0;
   logic              send;
   logic [AW-1:0]     mem_addr;
   logic [31:0]       mem_data;
   logic              mem_we;
   logic              busy;
   logic              done;
   logic              cpu_hold;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0]   bios_mem [IMG];
   int unsigned   log_addr [$];
   logic [31:0]   log_data [$];
   int unsigned   n_send   = 0;
   int unsigned   bios_idx = 0;
   int unsigned   cur      = 0;
   int unsigned   ph       = 3;   // cycles since the REQ cycle (3 = idle)
   bit            noise    = 1'b0;

   bios_loader #(
      .BOOT_SIZE   (BOOT),
      .CHUNK_WORDS (CW),
      .ADDR_W      (AW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .instructions (instructions),
      .send         (send),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_we       (mem_we),
      .busy         (busy),
      .done         (done),
      .cpu_hold     (cpu_hold)
   );

   always #5 clock = ~clock;

   // BIOS model and write monitor. Chunk is valid from the cycle after the
   // request through the latch cycle; in noise mode only the latch cycle is valid.
   always @(posedge clock) begin
      #1;
      if (reset) begin
         ph = 3;
      end else begin
         if (mem_we) begin
            log_addr.push_back(int'(mem_addr));
            log_data.push_back(mem_data);
         end
         if (send) begin
            n_send++;
            cur = bios_idx;
            bios_idx++;
            ph = 0;
         end else if (ph < 3) begin
            ph++;
         end
         if ((noise && ph == 2) || (!noise && ph == 1)) begin
            for (int w = 0; w < CW; w++)
               if (cur < NCH) instructions[32*w +: 32] = bios_mem[cur*CW + w];
         end else if (noise) begin
            for (int w = 0; w < CW; w++) instructions[32*w +: 32] = $urandom;
         end
      end
   end

   task automatic clear_log();
      @(negedge clock);
      log_addr.delete();
      log_data.delete();
      n_send   = 0;
      bios_idx = 0;
   endtask

   task automatic fill_bios();
      for (int i = 0; i < IMG; i++) bios_mem[i] = $urandom;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clock);
         #1;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_checks++; if (send !== 1'b0) $display("FAIL reset_send got %b want 0", send); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else n_pass++;
      n_checks++; if (mem_addr !== '0) $display("FAIL reset_addr got %0d want 0", mem_addr); else n_pass++;
      n_checks++; if (mem_data !== 32'h0) $display("FAIL reset_data got %h want 0", mem_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (cpu_hold !== 1'b1) $display("FAIL reset_hold got %b want 1", cpu_hold); else n_pass++;
      clear_log();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (busy !== 1'b0 || send !== 1'b0) $display("FAIL idle_quiet got busy=%b send=%b want 0 0", busy, send); else n_pass++;
   endtask

   // First copy: cycle-exact start-up, then the whole image with a marked final chunk.
   task automatic test_full_copy();
      bit ok;
      bit exp_send;
      bit exp_we;
      fill_bios();
      for (int i = 105; i < IMG; i++) bios_mem[i] = 32'hA000_0000 + 32'(i - 105);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);   // edge t samples start
      #1;
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) begin
            @(posedge clock);
            #1;
         end
         exp_send = (c == 1 || c == 9);
         exp_we   = (c >= 4 && c <= 8);
         n_checks++;
         if (send !== exp_send || mem_we !== exp_we)
            $display("FAIL timing_t+%0d got send=%b we=%b want send=%b we=%b", c, send, mem_we, exp_send, exp_we);
         else n_pass++;
         if (exp_we) begin
            n_checks++;
            if (mem_addr !== AW'(c - 4) || mem_data !== bios_mem[c-4])
               $display("FAIL timing_word_t+%0d got %0d:%h want %0d:%h", c, mem_addr, mem_data, c - 4, bios_mem[c-4]);
            else n_pass++;
         end
      end
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL full_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (n_send != NCH) $display("FAIL full_sends got %0d want %0d", n_send, NCH); else n_pass++;
      n_checks++; if (log_addr.size() != BOOT) $display("FAIL full_count got %0d want %0d", log_addr.size(), BOOT); else n_pass++;
      for (int i = 0; i < log_addr.size(); i++) begin
         n_checks++;
         if (log_addr[i] !== i || log_data[i] !== bios_mem[i])
            $display("FAIL full_write_%0d got %0d:%h want %0d:%h", i, log_addr[i], log_data[i], i, bios_mem[i]);
         else n_pass++;
      end
      n_checks++;
      if (log_data.size() == 0 || log_data[log_data.size()-1] !== 32'hA000_0003)
         $display("FAIL full_last_word got %h want a0000003", log_data.size() ? log_data[log_data.size()-1] : 32'hx);
      else n_pass++;
      n_checks++; if (cpu_hold !== 1'b0 || busy !== 1'b0) $display("FAIL full_release got hold=%b busy=%b want 0 0", cpu_hold, busy); else n_pass++;
   endtask

   // start held through most of a copy, sticky DONE, then reload from DONE.
   task automatic test_start_held();
      bit ok;
      bit seen;
      clear_log();
      fill_bios();
      start = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clock);
         #1;
         if (mem_we && mem_addr >= AW'(100)) begin
            seen = 1'b1;
            break;
         end
      end
      @(negedge clock);
      start = 1'b0;
      n_checks++; if (!seen) $display("FAIL held_progress got 0 want 1"); else n_pass++;
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL held_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (n_send != NCH) $display("FAIL held_sends got %0d want %0d", n_send, NCH); else n_pass++;
      n_checks++; if (log_addr.size() != BOOT) $display("FAIL held_count got %0d want %0d", log_addr.size(), BOOT); else n_pass++;
      for (int i = 0; i < log_addr.size(); i++) begin
         n_checks++;
         if (log_addr[i] !== i || log_data[i] !== bios_mem[i])
            $display("FAIL held_write_%0d got %0d:%h want %0d:%h", i, log_addr[i], log_data[i], i, bios_mem[i]);
         else n_pass++;
      end
      repeat (6) @(posedge clock);
      #1;
      n_checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || n_send != NCH)
         $display("FAIL done_sticky got done=%b hold=%b sends=%0d want 1 0 %0d", done, cpu_hold, n_send, NCH);
      else n_pass++;
      clear_log();
      fill_bios();
      repeat ($urandom_range(0, 3)) @(negedge clock);
      pulse_start();
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL reload_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (n_send != NCH) $display("FAIL reload_sends got %0d want %0d", n_send, NCH); else n_pass++;
      n_checks++; if (log_addr.size() != BOOT) $display("FAIL reload_count got %0d want %0d", log_addr.size(), BOOT); else n_pass++;
      for (int i = 0; i < log_addr.size(); i++) begin
         n_checks++;
         if (log_addr[i] !== i || log_data[i] !== bios_mem[i])
            $display("FAIL reload_write_%0d got %0d:%h want %0d:%h", i, log_addr[i], log_data[i], i, bios_mem[i]);
         else n_pass++;
      end
   endtask

   // Asynchronous reset at address 37, then a clean restart from address 0.
   task automatic test_abort();
      bit ok;
      bit seen;
      clear_log();
      fill_bios();
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clock);
         #1;
         if (mem_we && mem_addr == AW'(37)) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++; if (!seen) $display("FAIL abort_reach37 got 0 want 1"); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || send !== 1'b0 || mem_addr !== '0)
         $display("FAIL abort_async got we=%b busy=%b send=%b addr=%0d want 0 0 0 0", mem_we, busy, send, mem_addr);
      else n_pass++;
      repeat (2) @(posedge clock);
      clear_log();
      reset = 1'b0;
      fill_bios();
      repeat ($urandom_range(1, 4)) @(negedge clock);
      pulse_start();
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL abort_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (log_addr.size() != BOOT) $display("FAIL abort_count got %0d want %0d", log_addr.size(), BOOT); else n_pass++;
      for (int i = 0; i < log_addr.size(); i++) begin
         n_checks++;
         if (log_addr[i] !== i || log_data[i] !== bios_mem[i])
            $display("FAIL abort_write_%0d got %0d:%h want %0d:%h", i, log_addr[i], log_data[i], i, bios_mem[i]);
         else n_pass++;
      end
   endtask

   // Bus carries garbage in every cycle except the latch cycle.
   task automatic test_noise();
      bit ok;
      clear_log();
      fill_bios();
      noise = 1'b1;
      pulse_start();
      wait_done(ok);
      noise = 1'b0;
      n_checks++; if (!ok) $display("FAIL noise_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (log_addr.size() != BOOT) $display("FAIL noise_count got %0d want %0d", log_addr.size(), BOOT); else n_pass++;
      for (int i = 0; i < log_addr.size(); i++) begin
         n_checks++;
         if (log_addr[i] !== i || log_data[i] !== bios_mem[i])
            $display("FAIL noise_write_%0d got %0d:%h want %0d:%h", i, log_addr[i], log_data[i], i, bios_mem[i]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_full_copy();
      test_start_held();
      test_abort();
      test_noise();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
